// File: rtl/pcie_us_cfg_mgmt_arb.sv
// Round-robin arbiter/sequencer sharing the PCIe cfg_mgmt port among PORTS.
// Define CFG_MGMT_ARB_TIMEOUT_EN to build the done-timeout abort path.
module pcie_us_cfg_mgmt_arb #(
  parameter int PORTS   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS*10-1:0] s_req_addr,
  input  logic [PORTS*8-1:0]  s_req_function_number,
  input  logic [PORTS-1:0]    s_req_write,
  input  logic [PORTS*32-1:0] s_req_write_data,
  input  logic [PORTS*4-1:0]  s_req_byte_enable,
  input  logic [PORTS-1:0]    s_req_valid,
  output logic [PORTS-1:0]    s_req_ready,
  output logic [31:0]         s_resp_read_data,
  output logic [PORTS-1:0]    s_resp_valid,
  output logic [PORTS-1:0]    s_resp_timeout,
  output logic [9:0]          cfg_mgmt_addr,
  output logic [7:0]          cfg_mgmt_function_number,
  output logic                cfg_mgmt_write,
  output logic [31:0]         cfg_mgmt_write_data,
  output logic [3:0]          cfg_mgmt_byte_enable,
  output logic                cfg_mgmt_read,
  input  logic [31:0]         cfg_mgmt_read_data,
  input  logic                cfg_mgmt_read_write_done,
  output logic                busy
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gnt;
  logic [PW-1:0] w_gidx;
  logic          w_found;
  logic          w_grant;
  logic          w_done;
  logic          w_expire;

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!w_found && s_req_valid[(int'(r_ptr) + i) % PORTS]) begin
        w_found = 1'b1;
        w_gidx  = PW'((int'(r_ptr) + i) % PORTS);
      end
    end
  end

  // Re-arbitration waits while the completion pulse is still visible.
  assign w_grant = (r_state == IDLE) && w_found && !(|s_resp_valid);
  assign w_done  = (r_state == ACTIVE) && cfg_mgmt_read_write_done;

`ifdef CFG_MGMT_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_to;

  assign w_expire = (r_state == ACTIVE) &&
                    (r_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_to           <= 1'b0;
      s_resp_timeout <= '0;
    end else begin
      s_resp_timeout <= '0;
      unique case (r_state)
        ACTIVE: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_expire && !cfg_mgmt_read_write_done)
            r_to <= 1'b1;
        end
        RESP: begin
          s_resp_timeout[r_gnt] <= r_to;
          r_cnt <= '0;
          r_to  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expire         = 1'b0;
  assign s_resp_timeout   = '0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_next = ACTIVE;
      ACTIVE:  if (w_done || w_expire) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state                  <= IDLE;
      r_ptr                    <= '0;
      r_gnt                    <= '0;
      busy                     <= 1'b0;
      s_req_ready              <= '0;
      s_resp_valid             <= '0;
      s_resp_read_data         <= '0;
      cfg_mgmt_addr            <= '0;
      cfg_mgmt_function_number <= '0;
      cfg_mgmt_write           <= 1'b0;
      cfg_mgmt_write_data      <= '0;
      cfg_mgmt_byte_enable     <= '0;
      cfg_mgmt_read            <= 1'b0;
    end else begin
      r_state      <= w_next;
      busy         <= (w_next != IDLE);
      s_req_ready  <= '0;
      s_resp_valid <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            s_req_ready[w_gidx] <= 1'b1;
            r_gnt <= w_gidx;
            r_ptr <= (int'(w_gidx) == PORTS - 1) ?
                     '0 : w_gidx + 1'b1;
            cfg_mgmt_addr <=
              s_req_addr[int'(w_gidx)*10 +: 10];
            cfg_mgmt_function_number <=
              s_req_function_number[int'(w_gidx)*8 +: 8];
            cfg_mgmt_write_data <=
              s_req_write_data[int'(w_gidx)*32 +: 32];
            cfg_mgmt_byte_enable <=
              s_req_byte_enable[int'(w_gidx)*4 +: 4];
            cfg_mgmt_write <= s_req_write[w_gidx];
            cfg_mgmt_read  <= !s_req_write[w_gidx];
          end
        end
        ACTIVE: begin
          if (w_done || w_expire) begin
            cfg_mgmt_write <= 1'b0;
            cfg_mgmt_read  <= 1'b0;
            if (w_done)
              s_resp_read_data <= cfg_mgmt_read ?
                                  cfg_mgmt_read_data : '0;
            else
              s_resp_read_data <= '1;
          end
        end
        RESP:    s_resp_valid[r_gnt] <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_arb.sv
// Self-checking bench for pcie_us_cfg_mgmt_arb with a core responder model.
// Covers timeout abort when CFG_MGMT_ARB_TIMEOUT_EN is defined.
module tb_pcie_us_cfg_mgmt_arb;
  localparam int P  = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [P*10-1:0] s_req_addr = '0;
  logic [P*8-1:0]  s_req_function_number = '0;
  logic [P-1:0]    s_req_write = '0;
  logic [P*32-1:0] s_req_write_data = '0;
  logic [P*4-1:0]  s_req_byte_enable = '0;
  logic [P-1:0]    s_req_valid = '0;
  logic [P-1:0]    s_req_ready;
  logic [31:0]     s_resp_read_data;
  logic [P-1:0]    s_resp_valid;
  logic [P-1:0]    s_resp_timeout;
  logic [9:0]      cfg_mgmt_addr;
  logic [7:0]      cfg_mgmt_function_number;
  logic            cfg_mgmt_write;
  logic [31:0]     cfg_mgmt_write_data;
  logic [3:0]      cfg_mgmt_byte_enable;
  logic            cfg_mgmt_read;
  logic [31:0]     cfg_mgmt_read_data = '0;
  logic            cfg_mgmt_read_write_done = 1'b0;
  logic            busy;

  pcie_us_cfg_mgmt_arb #(.PORTS(P), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_req_addr(s_req_addr),
    .s_req_function_number(s_req_function_number),
    .s_req_write(s_req_write),
    .s_req_write_data(s_req_write_data),
    .s_req_byte_enable(s_req_byte_enable),
    .s_req_valid(s_req_valid),
    .s_req_ready(s_req_ready),
    .s_resp_read_data(s_resp_read_data),
    .s_resp_valid(s_resp_valid),
    .s_resp_timeout(s_resp_timeout),
    .cfg_mgmt_addr(cfg_mgmt_addr),
    .cfg_mgmt_function_number(cfg_mgmt_function_number),
    .cfg_mgmt_write(cfg_mgmt_write),
    .cfg_mgmt_write_data(cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable(cfg_mgmt_byte_enable),
    .cfg_mgmt_read(cfg_mgmt_read),
    .cfg_mgmt_read_data(cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done(cfg_mgmt_read_write_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int m_ptr = 0;

  logic [9:0]  a_addr [P];
  logic [7:0]  a_fn   [P];
  logic        a_wr   [P];
  logic [31:0] a_wd   [P];
  logic [3:0]  a_be   [P];

  // core responder: done after core_lat strobe cycles
  int          core_lat = 1;
  bit          core_en = 1'b1;
  bit          fix_en = 1'b0;
  logic [31:0] fix_data = '0;
  logic [31:0] core_data = '0;
  bit          stray_req = 1'b0;
  int          k = 0;

  always @(negedge clk) begin
    cfg_mgmt_read_write_done = 1'b0;
    cfg_mgmt_read_data = $urandom;
    if (cfg_mgmt_read || cfg_mgmt_write) begin
      k++;
      if (k == 1) core_data = fix_en ? fix_data : $urandom;
      if (core_en && k == core_lat) begin
        cfg_mgmt_read_write_done = 1'b1;
        cfg_mgmt_read_data = core_data;
      end
    end else begin
      k = 0;
      if (stray_req) begin
        cfg_mgmt_read_write_done = 1'b1;
        stray_req = 1'b0;
      end
    end
  end

  // observation of strobe windows and completions
  int    rise_cyc = 0;
  int    s_len = 0;
  bit    unstable = 1'b0;
  bit    saw_other = 1'b0;
  bit    was_read = 1'b0;
  bit    prev_strobe = 1'b0;
  logic [53:0] cap = '0;
  int    both_err = 0;
  int    multi_err = 0;
  int    to_err = 0;
  int          rsp_port [$];
  logic [31:0] rsp_data [$];
  bit          rsp_to   [$];
  int          rsp_cyc  [$];

  always @(negedge clk) begin
    if (cfg_mgmt_read && cfg_mgmt_write) both_err++;
    if ((cfg_mgmt_read || cfg_mgmt_write) && !prev_strobe) begin
      rise_cyc = cyc;
      s_len = 0;
      unstable = 1'b0;
      saw_other = 1'b0;
      was_read = cfg_mgmt_read;
      cap = {cfg_mgmt_addr, cfg_mgmt_function_number,
             cfg_mgmt_write_data, cfg_mgmt_byte_enable};
    end
    if (cfg_mgmt_read || cfg_mgmt_write) begin
      s_len++;
      if ({cfg_mgmt_addr, cfg_mgmt_function_number,
           cfg_mgmt_write_data, cfg_mgmt_byte_enable} !== cap)
        unstable = 1'b1;
      if (was_read ? cfg_mgmt_write : cfg_mgmt_read)
        saw_other = 1'b1;
    end
    if ($countones(s_req_ready) > 1) multi_err++;
    if ((s_resp_timeout & ~s_resp_valid) != 0) to_err++;
    if (s_resp_valid != 0) begin
      if ($countones(s_resp_valid) > 1) multi_err++;
      for (int i = 0; i < P; i++)
        if (s_resp_valid[i]) begin
          rsp_port.push_back(i);
          rsp_to.push_back(s_resp_timeout[i]);
        end
      rsp_data.push_back(s_resp_read_data);
      rsp_cyc.push_back(cyc);
    end
    prev_strobe = cfg_mgmt_read || cfg_mgmt_write;
  end

  function automatic int pick(int ptr, logic [P-1:0] m);
    for (int i = 0; i < P; i++)
      if (m[(ptr + i) % P]) return (ptr + i) % P;
    return -1;
  endfunction

  task automatic set_port(input int p, input logic wr,
                          input logic [9:0] ad, input logic [7:0] fn,
                          input logic [31:0] wd, input logic [3:0] be);
    a_wr[p] = wr; a_addr[p] = ad; a_fn[p] = fn;
    a_wd[p] = wd; a_be[p] = be;
    s_req_write[p] = wr;
    s_req_addr[p*10 +: 10] = ad;
    s_req_function_number[p*8 +: 8] = fn;
    s_req_write_data[p*32 +: 32] = wd;
    s_req_byte_enable[p*4 +: 4] = be;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic wait_free();
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk); #1;
      if (!busy && s_resp_valid == 0) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL settle: busy=%b resp_valid=%b, want idle", busy, s_resp_valid);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (s_req_ready != 0) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL grant_wait: no s_req_ready within bound");
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_chk++;
    if ({s_req_ready, s_resp_valid, s_resp_timeout, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %h want 0",
               {s_req_ready, s_resp_valid, s_resp_timeout, busy});
    end
    n_chk++;
    if ({cfg_mgmt_read, cfg_mgmt_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_strobe: got %b want 00", {cfg_mgmt_read, cfg_mgmt_write});
    end
    n_chk++;
    if ({cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write_data,
         cfg_mgmt_byte_enable, s_resp_read_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0",
               {cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write_data,
                cfg_mgmt_byte_enable, s_resp_read_data});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    bit ok;
    do_reset();
    fix_en = 1'b1; fix_data = 32'h00100406;
    core_en = 1'b1; core_lat = 3;
    set_port(2, 1'b0, 10'h004, 8'($urandom), $urandom, 4'hF);
    s_req_valid[2] = 1'b1;
    wait_ready(ok);
    s_req_valid[2] = 1'b0;
    n_chk++;
    if (s_req_ready !== 4'b0100 || !cfg_mgmt_read || cfg_mgmt_write ||
        cfg_mgmt_addr !== 10'h004) begin
      n_fail++;
      $display("FAIL read_issue: ready=%b rd=%b wr=%b addr=%h want 0100 1 0 004",
               s_req_ready, cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_addr);
    end
    wait_free();
    m_ptr = 3;
    n_chk++;
    if (s_len != 3 || unstable) begin
      n_fail++;
      $display("FAIL read_strobe: len=%0d unstable=%b want 3 0", s_len, unstable);
    end
    n_chk++;
    if (rsp_port.size() == 0 || rsp_port[$] != 2 ||
        rsp_data[$] !== 32'h00100406 || rsp_to[$] !== 1'b0) begin
      n_fail++;
      $display("FAIL read_resp: n=%0d want port 2 data 00100406 to 0", rsp_port.size());
    end
    n_chk++;
    if (rsp_cyc.size() == 0 || rsp_cyc[$] - rise_cyc != 4) begin
      n_fail++;
      $display("FAIL read_latency: got %0d want 4",
               rsp_cyc.size() ? rsp_cyc[$] - rise_cyc : -1);
    end
    fix_en = 1'b0;
  endtask

  task automatic test_write();
    bit ok;
    int lat = $urandom_range(1, 6);
    core_lat = lat;
    set_port(1, 1'b1, 10'h3F0, 8'h01, 32'hDEADBEEF, 4'b0011);
    s_req_valid[1] = 1'b1;
    wait_ready(ok);
    s_req_valid[1] = 1'b0;
    n_chk++;
    if (s_req_ready !== 4'b0010 || !cfg_mgmt_write || cfg_mgmt_read ||
        cfg_mgmt_addr !== 10'h3F0 || cfg_mgmt_function_number !== 8'h01 ||
        cfg_mgmt_write_data !== 32'hDEADBEEF || cfg_mgmt_byte_enable !== 4'b0011) begin
      n_fail++;
      $display("FAIL write_issue: ready=%b wr=%b rd=%b a=%h f=%h d=%h be=%b",
               s_req_ready, cfg_mgmt_write, cfg_mgmt_read, cfg_mgmt_addr,
               cfg_mgmt_function_number, cfg_mgmt_write_data, cfg_mgmt_byte_enable);
    end
    wait_free();
    m_ptr = 2;
    n_chk++;
    if (s_len != lat || unstable || saw_other) begin
      n_fail++;
      $display("FAIL write_strobe: len=%0d unstable=%b rd=%b want %0d 0 0",
               s_len, unstable, saw_other, lat);
    end
    n_chk++;
    if (rsp_port.size() == 0 || rsp_port[$] != 1 || rsp_data[$] !== 32'h0) begin
      n_fail++;
      $display("FAIL write_resp: data=%h want port 1 data 0",
               rsp_data.size() ? rsp_data[$] : 32'hx);
    end
  endtask

  task automatic test_arb(input logic [P-1:0] mask, input bit reraise,
                          input bit rand_lat);
    int exp_q[$];
    logic [31:0] expd_q[$];
    int g;
    int ng = 0;
    int last = -1;
    bit fin = 1'b0;
    bit rr = 1'b0;
    logic [P-1:0] expv;
    for (int p = 0; p < P; p++)
      if (mask[p])
        set_port(p, 1'($urandom), 10'($urandom), 8'($urandom),
                 $urandom, 4'($urandom));
    core_en = 1'b1;
    core_lat = rand_lat ? $urandom_range(1, 5) : 1;
    s_req_valid = mask;
    for (int c = 0; c < 600 && !fin; c++) begin
      @(negedge clk); #1;
      if (s_req_ready != 0) begin
        g = pick(m_ptr, s_req_valid);
        expv = (g < 0) ? '0 : (P'(1) << g);
        n_chk++;
        if (s_req_ready !== expv) begin
          n_fail++;
          $display("FAIL grant_order: got %b want %b", s_req_ready, expv);
        end
        if (g >= 0) begin
          n_chk++;
          if ({cfg_mgmt_addr, cfg_mgmt_function_number, cfg_mgmt_write_data,
               cfg_mgmt_byte_enable, cfg_mgmt_write, cfg_mgmt_read} !==
              {a_addr[g], a_fn[g], a_wd[g], a_be[g], a_wr[g], !a_wr[g]}) begin
            n_fail++;
            $display("FAIL grant_fields: port %0d a=%h f=%h d=%h be=%h",
                     g, cfg_mgmt_addr, cfg_mgmt_function_number,
                     cfg_mgmt_write_data, cfg_mgmt_byte_enable);
          end
          if (!rand_lat && last >= 0) begin
            n_chk++;
            if (cyc - last != 4) begin
              n_fail++;
              $display("FAIL grant_spacing: got %0d want 4", cyc - last);
            end
          end
          exp_q.push_back(g);
          expd_q.push_back(a_wr[g] ? 32'h0 : core_data);
          s_req_valid[g] = 1'b0;
          m_ptr = (g + 1) % P;
          if (reraise && g == 3 && !rr) begin
            s_req_valid[0] = 1'b1;
            rr = 1'b1;
          end
        end
        last = cyc;
        ng++;
      end
      if (s_resp_valid != 0) begin
        g = exp_q.size() ? exp_q.pop_front() : -1;
        expv = (g < 0) ? '0 : (P'(1) << g);
        n_chk++;
        if (s_resp_valid !== expv || s_resp_timeout !== '0 ||
            s_resp_read_data !== (expd_q.size() ? expd_q.pop_front() : 32'hx)) begin
          n_fail++;
          $display("FAIL resp_match: valid=%b to=%b data=%h want valid=%b",
                   s_resp_valid, s_resp_timeout, s_resp_read_data, expv);
        end
      end
      if (s_req_valid == 0 && exp_q.size() == 0 && !busy && s_resp_valid == 0)
        fin = 1'b1;
    end
    n_chk++;
    if (!fin || ng != $countones(mask) + int'(rr)) begin
      n_fail++;
      $display("FAIL arb_done: fin=%b grants=%0d want %0d",
               fin, ng, $countones(mask) + int'(rr));
    end
  endtask

  task automatic test_timeout();
    bit ok;
    fix_en = 1'b1; fix_data = $urandom;
`ifdef CFG_MGMT_ARB_TIMEOUT_EN
    core_en = 1'b0;
    set_port(3, 1'b0, 10'($urandom), 8'($urandom), $urandom, 4'hF);
    s_req_valid[3] = 1'b1;
    wait_ready(ok);
    s_req_valid[3] = 1'b0;
    wait_free();
    n_chk++;
    if (s_len != TO || rsp_port.size() == 0 || rsp_port[$] != 3 ||
        rsp_to[$] !== 1'b1 || rsp_data[$] !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL timeout_abort: len=%0d to=%b data=%h want %0d 1 ffffffff",
               s_len, rsp_to.size() ? rsp_to[$] : 1'bx,
               rsp_data.size() ? rsp_data[$] : 32'hx, TO);
    end
    core_en = 1'b1; core_lat = TO;
`else
    core_en = 1'b1; core_lat = 40;
`endif
    set_port(3, 1'b0, 10'($urandom), 8'($urandom), $urandom, 4'hF);
    s_req_valid[3] = 1'b1;
    wait_ready(ok);
    s_req_valid[3] = 1'b0;
    wait_free();
    m_ptr = 0;
    n_chk++;
    if (s_len != core_lat || rsp_port.size() == 0 || rsp_port[$] != 3 ||
        rsp_to[$] !== 1'b0 || rsp_data[$] !== fix_data) begin
      n_fail++;
      $display("FAIL late_done: len=%0d data=%h want %0d %h",
               s_len, rsp_data.size() ? rsp_data[$] : 32'hx, core_lat, fix_data);
    end
    fix_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n0;
    core_en = 1'b0;
    set_port(2, 1'b0, 10'($urandom), 8'($urandom), $urandom, 4'hF);
    s_req_valid[2] = 1'b1;
    wait_ready(ok);
    s_req_valid[2] = 1'b0;
    n0 = rsp_port.size();
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if (cfg_mgmt_read || cfg_mgmt_write || busy) begin
      n_fail++;
      $display("FAIL mid_reset: rd=%b wr=%b busy=%b want 0 0 0",
               cfg_mgmt_read, cfg_mgmt_write, busy);
    end
    rst = 1'b0;
    m_ptr = 0;
    repeat (4) @(negedge clk);
    n_chk++;
    if (rsp_port.size() != n0) begin
      n_fail++;
      $display("FAIL mid_reset_resp: got %0d responses want 0", rsp_port.size() - n0);
    end
    test_arb(4'b1001, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n0;
    int ng = 0;
    int last = -1;
    n0 = rsp_port.size();
    @(negedge clk); #1;
    stray_req = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    n_chk++;
    if (rsp_port.size() != n0 || busy) begin
      n_fail++;
      $display("FAIL stray_done: resp=%0d busy=%b want 0 0", rsp_port.size() - n0, busy);
    end
    core_en = 1'b1; core_lat = 1;
    set_port(1, 1'b0, 10'($urandom), 8'($urandom), $urandom, 4'hF);
    s_req_valid[1] = 1'b1;
    for (int c = 0; c < 100 && ng < 5; c++) begin
      @(negedge clk); #1;
      if (s_req_ready != 0) begin
        n_chk++;
        if (s_req_ready !== 4'b0010 || (last >= 0 && cyc - last != 4)) begin
          n_fail++;
          $display("FAIL b2b_grant: ready=%b gap=%0d want 0010 4",
                   s_req_ready, cyc - last);
        end
        last = cyc;
        ng++;
        if (ng == 5) s_req_valid[1] = 1'b0;
      end
    end
    s_req_valid[1] = 1'b0;
    wait_free();
    m_ptr = 2;
    n_chk++;
    if (ng != 5 || rsp_port.size() - n0 != 5) begin
      n_fail++;
      $display("FAIL b2b_count: grants=%0d resps=%0d want 5 5", ng, rsp_port.size() - n0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single_read();
    test_write();
    do_reset();
    test_arb(4'b1111, 1'b1, 1'b0);
    for (int r = 0; r < 12; r++)
      test_arb(P'($urandom_range(1, 15)), 1'b0, 1'b1);
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_chk++;
    if (both_err != 0 || multi_err != 0 || to_err != 0) begin
      n_fail++;
      $display("FAIL invariants: both=%0d multi=%0d to=%0d want 0 0 0",
               both_err, multi_err, to_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
